// File: rtl/sonic_tx_arbiter.sv
// sonic_tx_arbiter: round-robin arbiter for the shared PCIe TX path and the MSI request port
module sonic_tx_arbiter #(
  parameter int NUM_CLIENTS   = 3,
  parameter int GRANT_TIMEOUT = 64,
  parameter int TIMEOUT_W     = 8
) (
  input  logic                       clk_in,
  input  logic                       reset,
  input  logic                       init,
  input  logic [NUM_CLIENTS-1:0]     c_tx_ready,
  input  logic [NUM_CLIENTS-1:0]     c_tx_busy,
  input  logic [NUM_CLIENTS-1:0]     c_tx_req,
  input  logic [NUM_CLIENTS-1:0]     c_tx_dv,
  input  logic [NUM_CLIENTS-1:0]     c_tx_dfr,
  input  logic [NUM_CLIENTS-1:0]     c_tx_err,
  input  logic [128*NUM_CLIENTS-1:0] c_tx_desc,
  input  logic [128*NUM_CLIENTS-1:0] c_tx_data,
  output logic [NUM_CLIENTS-1:0]     c_tx_sel,
  output logic [NUM_CLIENTS-1:0]     c_tx_ready_others,
  output logic [NUM_CLIENTS-1:0]     c_tx_ack,
  input  logic [NUM_CLIENTS-1:0]     c_msi_ready,
  input  logic [NUM_CLIENTS-1:0]     c_msi_busy,
  input  logic [NUM_CLIENTS-1:0]     c_app_msi_req,
  output logic [NUM_CLIENTS-1:0]     c_msi_sel,
  output logic [NUM_CLIENTS-1:0]     c_app_msi_ack,
  output logic                       tx_req,
  output logic [127:0]               tx_desc,
  output logic                       tx_dv,
  output logic                       tx_dfr,
  output logic [127:0]               tx_data,
  output logic                       tx_err,
  input  logic                       tx_ack,
  input  logic                       tx_ws,
  output logic                       app_msi_req,
  input  logic                       app_msi_ack,
  output logic [2:0]                 tx_grant_idx,
  output logic [15:0]                tx_timeout_cnt
);
  typedef enum logic [1:0] {TX_IDLE, TX_GRANT, TX_BUSY} tx_state_t;
  typedef enum logic [1:0] {M_IDLE, M_GRANT, M_BUSY} msi_state_t;
  localparam logic [2:0] LAST_INIT = 3'(NUM_CLIENTS - 1);
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(GRANT_TIMEOUT - 1);
  tx_state_t tx_state_q, tx_state_d;
  msi_state_t m_state_q, m_state_d;
  logic [2:0] tx_g_q, tx_g_d, last_tx_q, last_tx_d;
  logic [2:0] m_g_q, m_g_d, last_msi_q, last_msi_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic [NUM_CLIENTS-1:0] others_q, others_d;
  logic [7:0] tx_rdy, tx_bsy, tx_rq, tx_v, tx_f, tx_e, m_rdy, m_bsy, m_rq;
  logic [1023:0] desc_p, data_p;
  logic tx_act, m_act, unused;
  // Client vectors padded to 8 so a 3-bit grant index selects them directly
  assign tx_rdy = 8'(c_tx_ready);
  assign tx_bsy = 8'(c_tx_busy);
  assign tx_rq  = 8'(c_tx_req);
  assign tx_v   = 8'(c_tx_dv);
  assign tx_f   = 8'(c_tx_dfr);
  assign tx_e   = 8'(c_tx_err);
  assign m_rdy  = 8'(c_msi_ready);
  assign m_bsy  = 8'(c_msi_busy);
  assign m_rq   = 8'(c_app_msi_req);
  assign desc_p = 1024'(c_tx_desc);
  assign data_p = 1024'(c_tx_data);
  assign unused = tx_ws;
  function automatic logic [2:0] rr_pick(input logic [7:0] rdy, input logic [2:0] last);
    logic [2:0] p;
    int k;
    p = last;
    for (int i = NUM_CLIENTS; i >= 1; i--) begin
      k = int'(last) + i;
      if (k >= NUM_CLIENTS) k = k - NUM_CLIENTS;
      if (rdy[3'(k)]) p = 3'(k);
    end
    return p;
  endfunction
  always_comb begin
    tx_state_d = tx_state_q;
    tx_g_d     = tx_g_q;
    last_tx_d  = last_tx_q;
    cnt_d      = '0;
    to_cnt_d   = to_cnt_q;
    if (init) begin
      tx_state_d = TX_IDLE;
      tx_g_d     = '0;
      last_tx_d  = LAST_INIT;
    end else begin
      case (tx_state_q)
        TX_IDLE: if (|c_tx_ready) begin
          tx_g_d     = rr_pick(tx_rdy, last_tx_q);
          tx_state_d = TX_GRANT;
        end
        TX_GRANT:
          if (tx_bsy[tx_g_q]) tx_state_d = TX_BUSY;
          else if (!tx_rdy[tx_g_q]) tx_state_d = TX_IDLE;
          else if (cnt_q == TO_LAST) begin
            tx_state_d = TX_IDLE;
            to_cnt_d   = to_cnt_q + 16'(to_cnt_q != 16'hFFFF);
          end else cnt_d = cnt_q + TIMEOUT_W'(1);
        TX_BUSY: if (!tx_bsy[tx_g_q]) begin
          tx_state_d = TX_IDLE;
          last_tx_d  = tx_g_q;
        end
        default: tx_state_d = TX_IDLE;
      endcase
    end
  end
  always_comb begin
    m_state_d  = m_state_q;
    m_g_d      = m_g_q;
    last_msi_d = last_msi_q;
    if (init) begin
      m_state_d  = M_IDLE;
      m_g_d      = '0;
      last_msi_d = LAST_INIT;
    end else begin
      case (m_state_q)
        M_IDLE: if (|c_msi_ready) begin
          m_g_d     = rr_pick(m_rdy, last_msi_q);
          m_state_d = M_GRANT;
        end
        M_GRANT:
          if (m_rq[m_g_q] || m_bsy[m_g_q]) m_state_d = M_BUSY;
          else if (!m_rdy[m_g_q]) m_state_d = M_IDLE;
        M_BUSY: if (!m_rq[m_g_q] && !m_bsy[m_g_q]) begin
          m_state_d  = M_IDLE;
          last_msi_d = m_g_q;
        end
        default: m_state_d = M_IDLE;
      endcase
    end
  end
  always_comb begin
    others_d = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      others_d[i] = tx_act && tx_g_q != 3'(i);
      for (int j = 0; j < NUM_CLIENTS; j++)
        if (j != i && c_tx_busy[j]) others_d[i] = 1'b1;
    end
    if (init) others_d = '0;
  end
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      m_state_q  <= M_IDLE;
      tx_g_q     <= '0;
      m_g_q      <= '0;
      last_tx_q  <= LAST_INIT;
      last_msi_q <= LAST_INIT;
      cnt_q      <= '0;
      to_cnt_q   <= '0;
      others_q   <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      m_state_q  <= m_state_d;
      tx_g_q     <= tx_g_d;
      m_g_q      <= m_g_d;
      last_tx_q  <= last_tx_d;
      last_msi_q <= last_msi_d;
      cnt_q      <= cnt_d;
      to_cnt_q   <= to_cnt_d;
      others_q   <= others_d;
    end
  end
  assign tx_act = tx_state_q != TX_IDLE;
  assign m_act  = m_state_q != M_IDLE;
  always_comb begin
    c_tx_sel  = '0;
    c_msi_sel = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      c_tx_sel[i]  = tx_act && tx_g_q == 3'(i);
      c_msi_sel[i] = m_act && m_g_q == 3'(i);
    end
  end
  assign c_tx_ack          = {NUM_CLIENTS{tx_ack}} & c_tx_sel;
  assign c_app_msi_ack     = {NUM_CLIENTS{app_msi_ack}} & c_msi_sel;
  assign c_tx_ready_others = others_q;
  assign tx_req            = tx_act & tx_rq[tx_g_q];
  assign tx_dv             = tx_act & tx_v[tx_g_q];
  assign tx_dfr            = tx_act & tx_f[tx_g_q];
  assign tx_err            = tx_act & tx_e[tx_g_q];
  assign tx_desc           = tx_act ? desc_p[{tx_g_q, 7'd0} +: 128] : '0;
  assign tx_data           = tx_act ? data_p[{tx_g_q, 7'd0} +: 128] : '0;
  assign app_msi_req       = m_act & m_rq[m_g_q];
  assign tx_grant_idx      = tx_g_q;
  assign tx_timeout_cnt    = to_cnt_q;
endmodule

// File: tb/tb_sonic_tx_arbiter.sv
// tb_sonic_tx_arbiter: directed checks of TX/MSI arbitration, timeout, init and async reset
module tb_sonic_tx_arbiter;
  localparam logic [127:0] D0 = 128'hD000_0000_0000_0000_0000_0000_0000_00A0;
  localparam logic [127:0] D1 = 128'hD111_1111_2222_3333_4444_5555_6666_77A1;
  localparam logic [127:0] D2 = 128'hD222_0000_FFFF_0000_FFFF_0000_FFFF_00A2;
  localparam logic [127:0] T0 = 128'h7000_0000_0000_0000_0000_0000_0000_00B0;
  localparam logic [127:0] T1 = 128'h7111_ABCD_EF01_2345_6789_ABCD_EF01_23B1;
  localparam logic [127:0] T2 = 128'h7222_5555_AAAA_5555_AAAA_5555_AAAA_55B2;
  logic clk_in = 1'b0, reset = 1'b1, init = 1'b0;
  logic [2:0] c_tx_ready = '0, c_tx_busy = '0, c_tx_req = '0, c_tx_dv = '0, c_tx_dfr = '0, c_tx_err = '0;
  logic [383:0] c_tx_desc = '0, c_tx_data = '0;
  logic [2:0] c_tx_sel, c_tx_ready_others, c_tx_ack;
  logic [2:0] c_msi_ready = '0, c_msi_busy = '0, c_app_msi_req = '0, c_msi_sel, c_app_msi_ack;
  logic tx_req, tx_dv, tx_dfr, tx_err, app_msi_req;
  logic tx_ack = 1'b0, tx_ws = 1'b0, app_msi_ack = 1'b0;
  logic [127:0] tx_desc, tx_data;
  logic [2:0] tx_grant_idx;
  logic [15:0] tx_timeout_cnt;
  int checks = 0, errors = 0;
  sonic_tx_arbiter dut (
    .clk_in(clk_in), .reset(reset), .init(init),
    .c_tx_ready(c_tx_ready), .c_tx_busy(c_tx_busy), .c_tx_req(c_tx_req),
    .c_tx_dv(c_tx_dv), .c_tx_dfr(c_tx_dfr), .c_tx_err(c_tx_err),
    .c_tx_desc(c_tx_desc), .c_tx_data(c_tx_data),
    .c_tx_sel(c_tx_sel), .c_tx_ready_others(c_tx_ready_others), .c_tx_ack(c_tx_ack),
    .c_msi_ready(c_msi_ready), .c_msi_busy(c_msi_busy), .c_app_msi_req(c_app_msi_req),
    .c_msi_sel(c_msi_sel), .c_app_msi_ack(c_app_msi_ack),
    .tx_req(tx_req), .tx_desc(tx_desc), .tx_dv(tx_dv), .tx_dfr(tx_dfr),
    .tx_data(tx_data), .tx_err(tx_err), .tx_ack(tx_ack), .tx_ws(tx_ws),
    .app_msi_req(app_msi_req), .app_msi_ack(app_msi_ack),
    .tx_grant_idx(tx_grant_idx), .tx_timeout_cnt(tx_timeout_cnt)
  );
  always #5 clk_in = ~clk_in;
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk_in);
      #2;
    end
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, want);
    end
  endtask
  initial begin
    c_tx_desc = {D2, D1, D0};
    c_tx_data = {T2, T1, T0};
    c_tx_req  = 3'b111;
    c_tx_dv   = 3'b010;
    c_tx_dfr  = 3'b001;
    c_tx_err  = 3'b100;
    #12;
    chk("rst_tx_sel", c_tx_sel, 3'b000);
    chk("rst_msi_sel", c_msi_sel, 3'b000);
    chk("rst_tx_req", tx_req, 1'b0);
    chk("rst_tx_desc", tx_desc, '0);
    chk("rst_others", c_tx_ready_others, 3'b000);
    chk("rst_idx", tx_grant_idx, 3'd0);
    chk("rst_tocnt", tx_timeout_cnt, 16'd0);
    #1 reset = 1'b0;
    // single requester, client 1
    c_tx_ready = 3'b010;
    cyc();
    chk("t1_sel", c_tx_sel, 3'b010);
    chk("t1_desc", tx_desc, D1);
    chk("t1_data", tx_data, T1);
    chk("t1_dv", tx_dv, 1'b1);
    chk("t1_dfr", tx_dfr, 1'b0);
    chk("t1_idx", tx_grant_idx, 3'd1);
    c_tx_busy = 3'b010;
    cyc();
    chk("t1_others", c_tx_ready_others, 3'b101);
    tx_ack = 1'b1;
    #1 chk("t1_ack", c_tx_ack, 3'b010);
    tx_ack = 1'b0;
    cyc(3);
    chk("t1_sel_busy", c_tx_sel, 3'b010);
    chk("t1_desc_busy", tx_desc, D1);
    c_tx_busy = 3'b000;
    c_tx_ready = 3'b000;
    cyc();
    chk("t1_sel_end", c_tx_sel, 3'b000);
    chk("t1_req_end", tx_req, 1'b0);
    chk("t1_desc_end", tx_desc, '0);
    chk("t1_idx_end", tx_grant_idx, 3'd1);
    // round robin over all three clients
    init = 1'b1;
    cyc();
    init = 1'b0;
    c_tx_ready = 3'b111;
    for (int k = 0; k < 4; k++) begin
      logic [2:0] oh;
      oh = 3'b001 << (k % 3);
      cyc();
      chk("rr_grant", c_tx_sel, oh);
      chk("rr_idx", tx_grant_idx, 3'(k % 3));
      c_tx_busy = oh;
      cyc(2);
      chk("rr_hold", c_tx_sel, oh);
      if (k == 0) chk("rr_others", c_tx_ready_others, 3'b110);
      if (k == 0) chk("rr_dfr", tx_dfr, 1'b1);
      cyc();
      c_tx_busy = 3'b000;
      cyc();
      chk("rr_dead", c_tx_sel, 3'b000);
    end
    c_tx_ready = 3'b000;
    // grant timeout
    init = 1'b1;
    cyc();
    init = 1'b0;
    c_tx_ready = 3'b100;
    cyc();
    chk("to_grant", c_tx_sel, 3'b100);
    c_tx_ready = 3'b101;
    cyc(63);
    chk("to_held", c_tx_sel, 3'b100);
    chk("to_cnt0", tx_timeout_cnt, 16'd0);
    cyc();
    chk("to_revoke", c_tx_sel, 3'b000);
    chk("to_cnt1", tx_timeout_cnt, 16'd1);
    cyc();
    chk("to_next", c_tx_sel, 3'b001);
    chk("to_next_idx", tx_grant_idx, 3'd0);
    c_tx_ready = 3'b000;
    cyc();
    chk("to_withdraw", c_tx_sel, 3'b000);
    // init during a grant, both arbiters
    c_tx_ready = 3'b010;
    c_msi_ready = 3'b001;
    cyc();
    chk("in_sel", c_tx_sel, 3'b010);
    chk("in_msi", c_msi_sel, 3'b001);
    init = 1'b1;
    cyc();
    init = 1'b0;
    c_tx_ready = 3'b000;
    c_msi_ready = 3'b000;
    chk("in_sel_clr", c_tx_sel, 3'b000);
    chk("in_msi_clr", c_msi_sel, 3'b000);
    chk("in_idx", tx_grant_idx, 3'd0);
    chk("in_tocnt", tx_timeout_cnt, 16'd1);
    // async reset mid-TLP
    c_tx_ready = 3'b001;
    cyc();
    c_tx_busy = 3'b001;
    cyc();
    chk("ar_sel", c_tx_sel, 3'b001);
    chk("ar_req", tx_req, 1'b1);
    reset = 1'b1;
    #1;
    chk("ar_sel_drop", c_tx_sel, 3'b000);
    chk("ar_req_drop", tx_req, 1'b0);
    chk("ar_desc_drop", tx_desc, '0);
    #1 reset = 1'b0;
    chk("ar_tocnt", tx_timeout_cnt, 16'd0);
    c_tx_busy = 3'b000;
    c_tx_ready = 3'b111;
    cyc();
    chk("ar_first", c_tx_sel, 3'b001);
    c_tx_ready = 3'b000;
    cyc();
    chk("ar_idle", c_tx_sel, 3'b000);
    // MSI grant concurrent with a TX grant
    c_tx_ready = 3'b010;
    cyc();
    c_tx_busy = 3'b010;
    cyc();
    c_msi_ready = 3'b100;
    c_app_msi_req = 3'b001;
    cyc();
    chk("msi_sel", c_msi_sel, 3'b100);
    chk("msi_tx_sel", c_tx_sel, 3'b010);
    chk("msi_req_other", app_msi_req, 1'b0);
    c_app_msi_req = 3'b100;
    app_msi_ack = 1'b1;
    tx_ack = 1'b1;
    #1;
    chk("msi_req", app_msi_req, 1'b1);
    chk("msi_ack", c_app_msi_ack, 3'b100);
    chk("msi_tx_ack", c_tx_ack, 3'b010);
    app_msi_ack = 1'b0;
    tx_ack = 1'b0;
    cyc();
    chk("msi_busy_sel", c_msi_sel, 3'b100);
    c_app_msi_req = 3'b000;
    c_msi_ready = 3'b000;
    cyc();
    chk("msi_done", c_msi_sel, 3'b000);
    chk("msi_tx_still", c_tx_sel, 3'b010);
    c_tx_busy = 3'b000;
    c_tx_ready = 3'b000;
    cyc();
    chk("msi_tx_done", c_tx_sel, 3'b000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
